// File: rtl/nco_sweep_pkg.sv
// Shared types and default widths for the NCO frequency-sweep scheduler.
// Holds the sweep FSM state enum and the default datapath widths.
package nco_sweep_pkg;

    localparam int NCO_ACC_WIDTH   = 32;
    localparam int NCO_DWELL_WIDTH = 16;
    localparam int NCO_HOP_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/nco_step_next.sv
// Combinational next-step generator for the sweep: add/subtract the hop
// increment, clamp to stop on overshoot or carry/borrow, flag termination.
// Ports: cur (current word), stop, delta, down -> next (clamped), term.
module nco_step_next
    import nco_sweep_pkg::*;
#(
    parameter int W = NCO_ACC_WIDTH
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] stop,
    input  logic [W-1:0] delta,
    input  logic         down,
    output logic [W-1:0] next,
    output logic         term
);

    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, cur} + {1'b0, delta};
    assign diff = {1'b0, cur} - {1'b0, delta};

    // A zero increment could never reach stop, so it ends the sweep at once.
    assign term = (delta == '0) || (down ? (cur <= stop) : (cur >= stop));

    // Clamp to stop by default; take the raw result only when it is in range.
    always_comb begin
        next = stop;
        if (down) begin
            if (!diff[W] && (diff[W-1:0] > stop))
                next = diff[W-1:0];
        end else begin
            if (!sum[W] && (sum[W-1:0] < stop))
                next = sum[W-1:0];
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep scheduler: steps nco_step from start to stop, holding
// each value for a programmable dwell, with start/abort control.
// Ports: aclk, rst_n (async low), start, abort, cfg_* (latched on start),
//   nco_step/nco_step_enable to the NCO, busy, done pulse, hop_count.
// Option macro NCO_SWEEP_CTRL_LOOP_EN: cfg_loop=1 restarts the sweep forever.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int ACC_WIDTH   = NCO_ACC_WIDTH,
    parameter int DWELL_WIDTH = NCO_DWELL_WIDTH,
    parameter int HOP_WIDTH   = NCO_HOP_WIDTH
) (
    input  logic                   aclk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ACC_WIDTH-1:0]   cfg_start_step,
    input  logic [ACC_WIDTH-1:0]   cfg_stop_step,
    input  logic [ACC_WIDTH-1:0]   cfg_delta_step,
    input  logic                   cfg_down,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    output logic [ACC_WIDTH-1:0]   nco_step,
    output logic                   nco_step_enable,
    output logic                   busy,
    output logic                   done,
    output logic [HOP_WIDTH-1:0]   hop_count
);

    sweep_state_t state, state_nxt;

    logic [ACC_WIDTH-1:0]   start_q;
    logic [ACC_WIDTH-1:0]   stop_q;
    logic [ACC_WIDTH-1:0]   delta_q;
    logic                   down_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [DWELL_WIDTH-1:0] dwell_eff;

    logic [ACC_WIDTH-1:0]   step_nxt;
    logic                   term;
    logic                   expire;
    logic                   go;
    logic                   load_first;
    logic                   load_next;
    logic                   restart;

    nco_step_next #(
        .W (ACC_WIDTH)
    ) u_next (
        .cur   (nco_step),
        .stop  (stop_q),
        .delta (delta_q),
        .down  (down_q),
        .next  (step_nxt),
        .term  (term)
    );

    assign dwell_eff = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
    assign expire    = (cnt == DWELL_WIDTH'(1));
    assign go        = start && !abort;

    assign busy = (state == ST_DWELL);
    assign done = (state == ST_DONE);

`ifdef NCO_SWEEP_CTRL_LOOP_EN
    logic loop_q;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)
            loop_q <= 1'b0;
        else if (load_first)
            loop_q <= cfg_loop;
    end
`else
    logic unused_cfg_loop;
    assign unused_cfg_loop = cfg_loop;
`endif

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        restart    = 1'b0;
        unique case (state)
            // DONE also accepts start, so a sweep can restart back to back.
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_nxt  = ST_DWELL;
                    load_first = 1'b1;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    if (!term) begin
                        load_next = 1'b1;
                    end else begin
`ifdef NCO_SWEEP_CTRL_LOOP_EN
                        if (loop_q)
                            restart = 1'b1;
                        else
                            state_nxt = ST_DONE;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            stop_q  <= '0;
            delta_q <= '0;
            down_q  <= 1'b0;
            dwell_q <= '0;
        end else if (load_first) begin
            start_q <= cfg_start_step;
            stop_q  <= cfg_stop_step;
            delta_q <= cfg_delta_step;
            down_q  <= cfg_down;
            dwell_q <= dwell_eff;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            nco_step        <= '0;
            nco_step_enable <= 1'b0;
            hop_count       <= '0;
            cnt             <= '0;
        end else begin
            nco_step_enable <= 1'b0;
            if (load_first) begin
                nco_step        <= cfg_start_step;
                nco_step_enable <= 1'b1;
                hop_count       <= HOP_WIDTH'(1);
                cnt             <= dwell_eff;
            end else if (load_next) begin
                nco_step        <= step_nxt;
                nco_step_enable <= 1'b1;
                if (hop_count != '1)
                    hop_count <= hop_count + HOP_WIDTH'(1);
                cnt             <= dwell_q;
            end else if (restart) begin
                nco_step        <= start_q;
                nco_step_enable <= 1'b1;
                hop_count       <= HOP_WIDTH'(1);
                cnt             <= dwell_q;
            end else if (state == ST_DWELL) begin
                cnt <= cnt - DWELL_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed scenarios plus random
// sweeps compared cycle by cycle against a list-of-steps reference model.
module tb_nco_sweep_ctrl;

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_start_step = '0;
    logic [31:0] cfg_stop_step = '0;
    logic [31:0] cfg_delta_step = '0;
    logic        cfg_down = 1'b0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic [31:0] nco_step;
    logic        nco_step_enable;
    logic        busy;
    logic        done;
    logic [15:0] hop_count;

    int n_checks = 0;
    int n_fail = 0;
    longint exp_q[$];

    nco_sweep_ctrl dut (
        .aclk            (aclk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_start_step  (cfg_start_step),
        .cfg_stop_step   (cfg_stop_step),
        .cfg_delta_step  (cfg_delta_step),
        .cfg_down        (cfg_down),
        .cfg_dwell       (cfg_dwell),
        .cfg_loop        (cfg_loop),
        .nco_step        (nco_step),
        .nco_step_enable (nco_step_enable),
        .busy            (busy),
        .done            (done),
        .hop_count       (hop_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Sequence of tuning words a sweep visits, in unbounded integer math.
    function automatic void build_model(longint s0, longint sp,
                                        longint dl, bit dn);
        longint s;
        exp_q.delete();
        s = s0;
        exp_q.push_back(s);
        while (dl != 0 && (dn ? (s > sp) : (s < sp))) begin
            s = dn ? s - dl : s + dl;
            if (dn ? (s < sp) : (s > sp))
                s = sp;
            exp_q.push_back(s);
        end
    endfunction

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] d, input logic dn,
                           input logic [15:0] dw);
        cfg_start_step = s;
        cfg_stop_step  = p;
        cfg_delta_step = d;
        cfg_down       = dn;
        cfg_dwell      = dw;
        cfg_loop       = 1'b0;
    endtask

    task automatic scramble();
        cfg_start_step = $urandom;
        cfg_stop_step  = $urandom;
        cfg_delta_step = $urandom;
        cfg_down       = 1'($urandom);
        cfg_dwell      = 16'($urandom);
        cfg_loop       = 1'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Runs one sweep with the cfg currently driven. pre: start is already
    // high at this negedge. chain: leave start high at the done cycle
    // with cfg taken from the nxt_* arguments.
    task automatic run_sweep(input string nm, input bit pre, input bit chain,
                             input logic [31:0] nxt_s, input logic [31:0] nxt_p,
                             input logic [31:0] nxt_d, input logic nxt_dn,
                             input logic [15:0] nxt_dw);
        longint s0 = cfg_start_step;
        longint sp = cfg_stop_step;
        longint dl = cfg_delta_step;
        bit dn = cfg_down;
        int d;
        int n;
        int k;
        logic [31:0] es;
        logic ee;
        d = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        build_model(s0, sp, dl, dn);
        n = exp_q.size();
        if (!pre) begin
            @(negedge aclk);
            start = 1'b1;
        end
        next_cycle();
        start = 1'b0;
        scramble();
        for (int c = 1; c <= n * d; c++) begin
            k = (c - 1) / d;
            es = 32'(exp_q[k]);
            ee = ((c - 1) % d) == 0;
            n_checks++;
            if (nco_step !== es || nco_step_enable !== ee || busy !== 1'b1 ||
                done !== 1'b0 || hop_count !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL %s cyc%0d got step=%h en=%b busy=%b done=%b hop=%0d want step=%h en=%b busy=1 done=0 hop=%0d",
                         nm, c, nco_step, nco_step_enable, busy, done,
                         hop_count, es, ee, k + 1);
            end
            next_cycle();
        end
        es = 32'(exp_q[n - 1]);
        n_checks++;
        if (nco_step !== es || nco_step_enable !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b1 || hop_count !== 16'(n)) begin
            n_fail++;
            $display("FAIL %s done_cyc%0d got step=%h en=%b busy=%b done=%b hop=%0d want step=%h en=0 busy=0 done=1 hop=%0d",
                     nm, n * d + 1, nco_step, nco_step_enable, busy, done,
                     hop_count, es, n);
        end
        if (chain) begin
            set_cfg(nxt_s, nxt_p, nxt_d, nxt_dn, nxt_dw);
            start = 1'b1;
        end else begin
            next_cycle();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || nco_step !== es ||
                hop_count !== 16'(n)) begin
                n_fail++;
                $display("FAIL %s idle got busy=%b done=%b step=%h hop=%0d want busy=0 done=0 step=%h hop=%0d",
                         nm, busy, done, nco_step, hop_count, es, n);
            end
        end
    endtask

    task automatic plain(input string nm);
        run_sweep(nm, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (nco_step !== '0 || nco_step_enable !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || hop_count !== '0) begin
            n_fail++;
            $display("FAIL reset got step=%h en=%b busy=%b done=%b hop=%0d want all 0",
                     nco_step, nco_step_enable, busy, done, hop_count);
        end
        @(negedge aclk);
        rst_n = 1'b1;
        next_cycle();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || nco_step_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b done=%b en=%b want 0 0 0",
                     busy, done, nco_step_enable);
        end
    endtask

    task automatic test_directed();
        set_cfg(32'd100, 32'd130, 32'd10, 1'b0, 16'd4);
        plain("ascending");
        set_cfg(32'd100, 32'd125, 32'd10, 1'b0, 16'd2);
        plain("clamp");
        set_cfg(32'd5, 32'd0, 32'd10, 1'b1, 16'd1);
        plain("desc_wrap");
        set_cfg(32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd10, 1'b0, 16'd3);
        plain("asc_overflow");
    endtask

    task automatic test_single_hop();
        set_cfg(32'd200, 32'd100, 32'd5, 1'b0, 16'd2);
        plain("past_stop");
        set_cfg(32'd50, 32'd100, 32'd0, 1'b0, 16'd3);
        plain("zero_delta");
        set_cfg(32'd10, 32'd30, 32'd10, 1'b0, 16'd0);
        plain("dwell_zero");
    endtask

    task automatic test_back_to_back();
        set_cfg(32'd1000, 32'd970, 32'd15, 1'b1, 16'd2);
        run_sweep("b2b_first", 1'b0, 1'b1,
                  32'd7, 32'd20, 32'd4, 1'b0, 16'd3);
        run_sweep("b2b_second", 1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_abort();
        logic [31:0] es;
        set_cfg(32'd100, 32'd130, 32'd10, 1'b0, 16'd4);
        @(negedge aclk);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            es = 32'(100 + 10 * ((c - 1) / 4));
            n_checks++;
            if (nco_step !== es || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_run cyc%0d got step=%h busy=%b done=%b want step=%h busy=1 done=0",
                         c, nco_step, busy, done, es);
            end
            if (c == 3) begin
                start = 1'b1;
                scramble();
            end
            if (c == 4)
                start = 1'b0;
            if (c == 6)
                abort = 1'b1;
            next_cycle();
        end
        abort = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || nco_step !== 32'd110 ||
                hop_count !== 16'd2 || nco_step_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold cyc%0d got busy=%b done=%b step=%h hop=%0d en=%b want 0 0 0000006e 2 0",
                         c, busy, done, nco_step, hop_count, nco_step_enable);
            end
            next_cycle();
        end
    endtask

    task automatic test_start_abort_idle();
        set_cfg(32'd1, 32'd9, 32'd1, 1'b0, 16'd1);
        @(negedge aclk);
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || nco_step_enable !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort got busy=%b en=%b done=%b want 0 0 0",
                     busy, nco_step_enable, done);
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(32'd100, 32'd130, 32'd10, 1'b0, 16'd4);
        @(negedge aclk);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (nco_step !== '0 || nco_step_enable !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || hop_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got step=%h en=%b busy=%b done=%b hop=%0d want all 0",
                     nco_step, nco_step_enable, busy, done, hop_count);
        end
        @(negedge aclk);
        rst_n = 1'b1;
        next_cycle();
        n_checks++;
        if (busy !== 1'b0 || nco_step !== '0) begin
            n_fail++;
            $display("FAIL reset_release got busy=%b step=%h want 0 0",
                     busy, nco_step);
        end
        set_cfg(32'd40, 32'd10, 32'd7, 1'b1, 16'd2);
        plain("post_reset");
    endtask

    task automatic test_loop();
`ifdef NCO_SWEEP_CTRL_LOOP_EN
        int k;
        logic [31:0] es;
        set_cfg(32'd100, 32'd130, 32'd10, 1'b0, 16'd4);
        cfg_loop = 1'b1;
        @(negedge aclk);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        scramble();
        for (int c = 1; c <= 40; c++) begin
            k = ((c - 1) / 4) % 4;
            es = 32'(100 + 10 * k);
            n_checks++;
            if (nco_step !== es || busy !== 1'b1 || done !== 1'b0 ||
                nco_step_enable !== (((c - 1) % 4) == 0) ||
                hop_count !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL loop cyc%0d got step=%h en=%b busy=%b done=%b hop=%0d want step=%h hop=%0d",
                         c, nco_step, nco_step_enable, busy, done, hop_count,
                         es, k + 1);
            end
            if (c == 40)
                abort = 1'b1;
            next_cycle();
        end
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || nco_step !== 32'd110) begin
            n_fail++;
            $display("FAIL loop_abort got busy=%b done=%b step=%h want 0 0 0000006e",
                     busy, done, nco_step);
        end
`else
        set_cfg(32'd100, 32'd130, 32'd10, 1'b0, 16'd4);
        cfg_loop = 1'b1;
        plain("loop_ignored");
`endif
    endtask

    task automatic test_random();
        longint s0;
        longint sp;
        longint span;
        bit dn;
        for (int i = 0; i < 12; i++) begin
            s0 = longint'($urandom);
            if (i % 4 == 0)
                s0 = (i % 8 == 0) ? longint'(32'hFFFF_FFF0) : 64'd20;
            dn = 1'($urandom);
            span = longint'($urandom_range(0, 150));
            sp = dn ? s0 - span : s0 + span;
            if (sp < 0)
                sp = 0;
            if (sp > 64'hFFFF_FFFF)
                sp = 64'hFFFF_FFFF;
            if ($urandom_range(0, 4) == 0)
                dn = ~dn;
            set_cfg(32'(s0), 32'(sp), 32'($urandom_range(1, 30)), dn,
                    16'($urandom_range(0, 4)));
            plain($sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_single_hop();
        test_back_to_back();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        test_loop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
